// File: rtl/mvm_tile_engine.sv
// mvm_tile_engine
// Tiled matrix-vector multiply-accumulate engine. Each accepted beat carries
// one activation tile (matH elements) and one weight tile (matH x matW). The
// per-column dot products are summed into matW accumulators across up to
// maxTiles beats. The finished result is then presented on y_o with a
// valid/ready handshake.
//
// Optional feature: define MVM_TILE_RELU_EN to clamp negative columns to zero
// when a signed-mode result is loaded into y_o. Unsigned results are never
// modified.
module mvm_tile_engine #(
    parameter int activationBits = 8,
    parameter int matBits        = 8,
    parameter int matH           = 3,
    parameter int matW           = 3,
    parameter int maxTiles       = 4,
    localparam int rowBits  = ($clog2(matH) < 1) ? 1 : $clog2(matH),
    localparam int tileBits = ($clog2(maxTiles) < 1) ? 1 : $clog2(maxTiles),
    localparam int outBits  = activationBits + matBits + rowBits + tileBits,
    localparam int cntBits  = $clog2(maxTiles + 1)
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic [matH-1:0][activationBits-1:0]     x_i,
    input  logic [matH-1:0][matW-1:0][matBits-1:0]  w_i,
    input  logic                                    in_valid_i,
    input  logic                                    in_last_i,
    input  logic                                    signed_i,
    output logic                                    in_ready_o,
    output logic [matW-1:0][outBits-1:0]            y_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [cntBits-1:0]                      tile_cnt_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                        state;
    logic                          mode_signed;
    logic [matW-1:0][outBits-1:0]  acc;
    logic [matW-1:0][outBits-1:0]  prod;
    logic [matW-1:0][outBits-1:0]  acc_next;
    logic [matW-1:0][outBits-1:0]  y_load;
    logic [cntBits-1:0]            cnt_next;
    logic                          eff_signed;
    logic                          beat;
    logic                          finish;

    // Widen an activation to the accumulator width, sign- or zero-extended.
    function automatic logic [outBits-1:0] ext_x(input logic [activationBits-1:0] v,
                                                 input logic s);
        ext_x = {{(outBits-activationBits){s & v[activationBits-1]}}, v};
    endfunction

    // Widen a weight to the accumulator width, sign- or zero-extended.
    function automatic logic [outBits-1:0] ext_w(input logic [matBits-1:0] v,
                                                 input logic s);
        ext_w = {{(outBits-matBits){s & v[matBits-1]}}, v};
    endfunction

    assign beat = in_valid_i & in_ready_o;

    // The first beat of a transaction uses the live signed_i; later beats use
    // the mode that was latched on that first beat.
    assign eff_signed = (state == IDLE) ? signed_i : mode_signed;

    // Tile product, next accumulator value, next tile count and completion test.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        prod     = '0;
        acc_next = '0;
        for (int k = 0; k < matW; k++) begin
            for (int i = 0; i < matH; i++) begin
                // Truncated outBits multiply is exact modulo 2^outBits for
                // both extension modes.
                prod[k] = prod[k] + ext_x(x_i[i], eff_signed) * ext_w(w_i[i][k], eff_signed);
            end
            acc_next[k] = (state == IDLE) ? prod[k] : acc[k] + prod[k];
        end
        cnt_next = (state == IDLE) ? cntBits'(1) : tile_cnt_o + cntBits'(1);
        finish   = in_last_i | (cnt_next == cntBits'(maxTiles));
    end

    // Value loaded into y_o when the transaction completes.
    always_comb begin
        y_load = acc_next;
`ifdef MVM_TILE_RELU_EN
        for (int k = 0; k < matW; k++) begin
            if (eff_signed && acc_next[k][outBits-1]) begin
                y_load[k] = '0;
            end
        end
`endif
    end

    // Control FSM with registered handshake outputs, accumulators and result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            mode_signed <= 1'b0;
            acc         <= '0;
            y_o         <= '0;
            out_valid_o <= 1'b0;
            tile_cnt_o  <= '0;
            in_ready_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE, ACCUM: begin
                    in_ready_o <= 1'b1;
                    if (beat) begin
                        acc        <= acc_next;
                        tile_cnt_o <= cnt_next;
                        if (state == IDLE) begin
                            mode_signed <= signed_i;
                        end
                        if (finish) begin
                            state       <= DONE;
                            y_o         <= y_load;
                            out_valid_o <= 1'b1;
                            in_ready_o  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        tile_cnt_o  <= '0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_tile_engine.sv
// tb_mvm_tile_engine
// Directed bench for mvm_tile_engine at default parameters. Stimulus tasks push
// the hand-computed result of each transaction into a queue, and a monitor pops
// and compares whenever a new result appears on the output.
module tb_mvm_tile_engine;

    localparam int AB = 8;
    localparam int MB = 8;
    localparam int MH = 3;
    localparam int MW = 3;
    localparam int MT = 4;
    localparam int OB = 20;
    localparam int CW = 3;

    typedef logic [MH-1:0][AB-1:0]         x_t;
    typedef logic [MH-1:0][MW-1:0][MB-1:0] w_t;
    typedef logic [MW-1:0][OB-1:0]         y_t;
    typedef struct packed {
        y_t            y;
        logic [CW-1:0] cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           nrst;
    x_t             x_i;
    w_t             w_i;
    logic           in_valid_i;
    logic           in_last_i;
    logic           signed_i;
    logic           in_ready_o;
    y_t             y_o;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [CW-1:0]  tile_cnt_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   seen     = 1'b0;

    mvm_tile_engine #(
        .activationBits(AB),
        .matBits       (MB),
        .matH          (MH),
        .matW          (MW),
        .maxTiles      (MT)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .x_i        (x_i),
        .w_i        (w_i),
        .in_valid_i (in_valid_i),
        .in_last_i  (in_last_i),
        .signed_i   (signed_i),
        .in_ready_o (in_ready_o),
        .y_o        (y_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .tile_cnt_o (tile_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic x_t mk_x(input int a, input int b, input int c);
        mk_x[0] = AB'(a);
        mk_x[1] = AB'(b);
        mk_x[2] = AB'(c);
    endfunction

    function automatic w_t w_uni(input int v);
        for (int i = 0; i < MH; i++)
            for (int k = 0; k < MW; k++)
                w_uni[i][k] = MB'(v);
    endfunction

    // Column k weighted by k+1 on every row.
    function automatic w_t w_cols();
        for (int i = 0; i < MH; i++)
            for (int k = 0; k < MW; k++)
                w_cols[i][k] = MB'(k + 1);
    endfunction

    function automatic y_t y3(input int a, input int b, input int c);
        y3[0] = OB'(a);
        y3[1] = OB'(b);
        y3[2] = OB'(c);
    endfunction

    function automatic exp_t mk_exp(input y_t y, input int cnt);
        mk_exp.y   = y;
        mk_exp.cnt = CW'(cnt);
    endfunction

    // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send_beat(input x_t x, input w_t w, input logic last, input logic sgn);
        int n = 0;
        @(negedge clk);
        x_i        = x;
        w_i        = w;
        in_last_i  = last;
        signed_i   = sgn;
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready", in_ready_o, 1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Wait for a result, stall for hold cycles, then accept it.
    task automatic consume(input int hold);
        int n = 0;
        @(negedge clk);
        while (!out_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", out_valid_o, 1);
        repeat (hold) @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    // Scoreboard monitor: compare once per newly presented result.
    always @(negedge clk) begin
        if (!nrst || !out_valid_o) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 64'(sb.size()), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_y", y_o, e.y);
                check("sb_cnt", tile_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst        = 1'b0;
        x_i         = '0;
        w_i         = '0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        signed_i    = 1'b0;
        out_ready_i = 1'b0;

        // Reset state
        #3;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_y", y_o, 0);
        check("rst_cnt", tile_cnt_o, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready_o, 1);

        // Unsigned single tile: 1*2+2*2+3*2 = 12 per column, latency 1
        sb.push_back(mk_exp(y3(12, 12, 12), 1));
        send_beat(mk_x(1, 2, 3), w_uni(2), 1'b1, 1'b0);
        check("latency1_valid", out_valid_o, 1);
        check("done_in_ready", in_ready_o, 0);
        consume(0);

        // Unsigned 3 tiles of 255s: 3 * 3 * 65025 = 585225 per column
        sb.push_back(mk_exp(y3(585225, 585225, 585225), 3));
        send_beat(mk_x(255, 255, 255), w_uni(255), 1'b0, 1'b0);
        send_beat(mk_x(255, 255, 255), w_uni(255), 1'b0, 1'b0);
        send_beat(mk_x(255, 255, 255), w_uni(255), 1'b1, 1'b0);
        check("three_tile_cnt", tile_cnt_o, 3);
        consume(2);

        // Signed single tile: -4 + 8 - 12 = -8 per column
`ifdef MVM_TILE_RELU_EN
        sb.push_back(mk_exp(y3(0, 0, 0), 1));
`else
        sb.push_back(mk_exp(y3(-8, -8, -8), 1));
`endif
        send_beat(mk_x(-1, 2, -3), w_uni(4), 1'b1, 1'b1);
        consume(0);

        // Distinct columns: (1+2+3)*(k+1) = 6, 12, 18 in both modes
        sb.push_back(mk_exp(y3(6, 12, 18), 1));
        send_beat(mk_x(1, 2, 3), w_cols(), 1'b1, 1'b0);
        consume(1);
        sb.push_back(mk_exp(y3(6, 12, 18), 1));
        send_beat(mk_x(1, 2, 3), w_cols(), 1'b1, 1'b1);
        consume(0);

        // Mode latched on first beat only: 255*255 unsigned twice = 130050
        sb.push_back(mk_exp(y3(130050, 130050, 130050), 2));
        send_beat(mk_x(255, 0, 0), w_uni(255), 1'b0, 1'b0);
        send_beat(mk_x(255, 0, 0), w_uni(255), 1'b1, 1'b1);
        consume(0);

        // Idle gap inside ACCUM holds state: 3 + 3 = 6
        sb.push_back(mk_exp(y3(6, 6, 6), 2));
        send_beat(mk_x(1, 1, 1), w_uni(1), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("gap_cnt", tile_cnt_o, 1);
        check("gap_in_ready", in_ready_o, 1);
        check("gap_out_valid", out_valid_o, 0);
        send_beat(mk_x(1, 1, 1), w_uni(1), 1'b1, 1'b0);
        consume(0);

        // maxTiles forces DONE after 4 beats without in_last_i
        sb.push_back(mk_exp(y3(4, 4, 4), 4));
        for (int b = 0; b < MT; b++) begin
            send_beat(mk_x(1, 0, 0), w_uni(1), 1'b0, 1'b0);
        end
        check("max_in_ready", in_ready_o, 0);
        check("max_out_valid", out_valid_o, 1);
        check("max_cnt", tile_cnt_o, 4);

        // Stall in DONE for 5 cycles with a competing beat offered
        @(negedge clk);
        x_i        = mk_x(9, 9, 9);
        w_i        = w_uni(9);
        in_last_i  = 1'b1;
        in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_y", y_o, y3(4, 4, 4));
            check("stall_cnt", tile_cnt_o, 4);
            check("stall_in_ready", in_ready_o, 0);
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        check("post_hs_valid", out_valid_o, 0);
        check("post_hs_cnt", tile_cnt_o, 0);
        check("post_hs_y_retained", y_o, y3(4, 4, 4));
        check("post_hs_in_ready", in_ready_o, 1);
        repeat (3) @(negedge clk);
        check("idle_cnt", tile_cnt_o, 0);
        check("idle_out_valid", out_valid_o, 0);

        // Reset mid-ACCUM discards the partial result
        send_beat(mk_x(255, 255, 255), w_uni(255), 1'b0, 1'b0);
        send_beat(mk_x(255, 255, 255), w_uni(255), 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b0;
        #2;
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_y", y_o, 0);
        check("mid_rst_cnt", tile_cnt_o, 0);
        check("mid_rst_in_ready", in_ready_o, 0);
        @(negedge clk);
        nrst = 1'b1;
        sb.push_back(mk_exp(y3(3, 3, 3), 1));
        send_beat(mk_x(1, 1, 1), w_uni(1), 1'b1, 1'b0);
        consume(0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_tile_engine.md
MVM_TILE_ENGINE -- requirements
Module: mvm_tile_engine

Interface
REQ-001 Parameter activationBits, default 8: bits per activation element.
REQ-002 Parameter matBits, default 8: bits per weight element.
REQ-003 Parameter matH, default 3: rows (activations per tile).
REQ-004 Parameter matW, default 3: columns (outputs).
REQ-005 Parameter maxTiles, default 4: maximum tiles accumulated per transaction, at least 1.
REQ-006 Localparam outBits = activationBits + matBits + $clog2(matH) + $clog2(maxTiles), minimum term 1 for each clog2.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 nrst  input  1  reset, asynchronous and active-low.
REQ-009 x_i  input  [matH-1:0][activationBits-1:0]  activation tile.
REQ-010 w_i  input  [matH-1:0][matW-1:0][matBits-1:0]  weight tile.
REQ-011 in_valid_i  input  1  tile beat valid.
REQ-012 in_last_i  input  1  final tile of transaction; qualified by in_valid_i.
REQ-013 signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-014 in_ready_o  output  1  engine accepts a beat.
REQ-015 y_o  output  [matW-1:0][outBits-1:0]  accumulated result.
REQ-016 out_valid_o  output  1  y_o holds a completed result.
REQ-017 out_ready_i  input  1  consumer accepts result.
REQ-018 tile_cnt_o  output  $clog2(maxTiles+1)  tiles accepted in current transaction.

Function
REQ-019 Beat accepted when in_valid_i and in_ready_o are both 1 at a rising edge.
REQ-020 FSM states IDLE, ACCUM, DONE; in_ready_o = 1 in IDLE and ACCUM, 0 in DONE.
REQ-021 IDLE, beat accepted: acc[k] = tile product, tile_cnt_o = 1, latch mode from signed_i; go DONE if in_last_i or maxTiles==1, else ACCUM.
REQ-022 ACCUM, beat accepted: acc[k] += tile product, tile_cnt_o increments; go DONE if in_last_i or new count == maxTiles.
REQ-023 Tile product for column k = sum over i of x_i[i]*w_i[i][k], operands sign-extended if latched mode is signed, zero-extended otherwise, computed at outBits.
REQ-024 signed_i is sampled only on the first beat; changes during ACCUM are ignored.
REQ-025 Entering DONE: y_o loaded with acc, out_valid_o = 1 the cycle after the last beat is accepted (latency 1).
REQ-026 DONE: y_o and out_valid_o hold until out_ready_i = 1; then out_valid_o = 0, tile_cnt_o = 0, go IDLE next cycle.
REQ-027 No input beat is accepted in the DONE cycle in which out_ready_i is sampled high.
REQ-028 y_o retains last result after handshake until the next DONE entry.
REQ-029 Accumulation is modular in outBits; no overflow detection.
REQ-030 in_valid_i low in ACCUM: acc and tile_cnt_o hold indefinitely.

Reset
REQ-031 nrst low asynchronously forces IDLE, acc, y_o, out_valid_o, tile_cnt_o to 0, mode to unsigned.
REQ-032 in_ready_o = 1 from the first edge after nrst deasserts.
REQ-033 Reset mid-ACCUM or mid-DONE discards partial/unconsumed results with no output.

Configuration
REQ-034 Macro MVM_TILE_RELU_EN defined: on DONE entry in signed mode, negative acc columns load y_o as 0; unsigned mode unaffected.
REQ-035 Macro MVM_TILE_RELU_EN undefined: y_o loads acc unmodified in both modes.

Verification
REQ-036 Unsigned single tile, x={1,2,3}, w all 2, in_last_i=1 -> next cycle out_valid_o=1, y_o={12,12,12}.
REQ-037 Unsigned 3 tiles of x={255,255,255}, w all 255 -> y_o each 585225, tile_cnt_o=3.
REQ-038 Signed single tile, x={-1,2,-3}, w all 4 -> y_o each -8 (two's complement); with MVM_TILE_RELU_EN -> 0.
REQ-039 maxTiles=4, 4 beats with in_last_i=0 -> DONE forced after 4th beat, in_ready_o=0.
REQ-040 out_ready_i held 0 for 5 cycles in DONE with in_valid_i=1 -> y_o stable, no beat accepted, tile_cnt_o unchanged.
REQ-041 nrst pulsed low after 2 beats -> out_valid_o=0, y_o=0, next transaction x={1,1,1}, w all 1 -> y_o={3,3,3}.
